hdlc_tx_framer: RTL and testbench

Bit-level HDLC transmit framer and the counterpart of the Rx channel. It pulls frame bytes from the Tx buffer and serialises them one bit per Clk, LSB first. It adds the opening flag, performs zero insertion, appends the 16-bit FCS, adds the closing flag, and generates the abort sequence. Its output Tx connects directly to the Hdlc Tx pin and can be looped back to Rx.

---
 rtl/hdlc_tx_framer_if.sv | 20 ++
 rtl/hdlc_tx_framer.sv | 143 ++++++++++++++
 tb/tb_hdlc_tx_framer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdlc_tx_framer_if.sv
// hdlc_tx_framer_if: Tx buffer handshake, control and serial line of the HDLC transmit framer.
interface hdlc_tx_framer_if #(parameter int SIZE_W = 8);
  logic              Tx_Enable;
  logic [SIZE_W-1:0] Tx_FrameSize;
  logic [7:0]        Tx_DataOutBuff;
  logic              Tx_RdBuff;
  logic              Tx_AbortFrame;
  logic              Tx;
  logic              Tx_ValidFrame;
  logic              Tx_Done;
  logic              Tx_AbortedTrans;
  modport master (
    input  Tx_Enable, Tx_FrameSize, Tx_DataOutBuff, Tx_AbortFrame,
    output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
  modport slave (
    output Tx_Enable, Tx_FrameSize, Tx_DataOutBuff, Tx_AbortFrame,
    input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
  );
endinterface

// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: HDLC serialiser with flags, zero insertion, CRC-16/X.25 FCS and abort sequence.
// Define TX_IDLE_FLAGS_EN to transmit continuous 0x7E flags while idle.
module hdlc_tx_framer #(
  parameter int MAX_BYTES = 126,
  parameter int SIZE_W    = 8
) (
  input logic Clk,
  input logic Rst,
  hdlc_tx_framer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FLAG_START, DATA, FCS, FLAG_END, ABORT} state_t;
  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [7:0] ABRT = 8'h7F;
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SIZE_W-1:0] byte_q, byte_d, size_q, size_d;
  logic [7:0]        hold_q, hold_d, data_q, data_d;
  logic [15:0]       crc_q, crc_d;
  logic [2:0]        ones_q, ones_d;
  logic              pend_q, pend_d, rd_dly_q, stuff_d;
  logic              tx_q, tx_d, rd_q, rd_d, valid_q, done_q, ab_q, ab_d;
  logic              start_ok, go, abort_req, stuff_now;
  // cnt_q/state_q always describe the bit currently on the line; a stuffed cycle leaves them untouched
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    size_d    = size_q;
    data_d    = data_q;
    crc_d     = crc_q;
    pend_d    = pend_q;
    stuff_d   = 1'b0;
    ab_d      = 1'b0;
    hold_d    = rd_dly_q ? bus.Tx_DataOutBuff : hold_q;
    start_ok  = bus.Tx_Enable && bus.Tx_FrameSize != '0 && bus.Tx_FrameSize <= SIZE_W'(MAX_BYTES);
    abort_req = bus.Tx_AbortFrame && (state_q == FLAG_START || state_q == DATA || state_q == FCS);
    stuff_now = (state_q == DATA || state_q == FCS) && ones_q == 3'd5;
`ifdef TX_IDLE_FLAGS_EN
    go        = (pend_q || start_ok) && cnt_q[2:0] == 3'd7;
`else
    go        = start_ok;
`endif
    if (abort_req) begin
      state_d = ABORT;
      cnt_d   = '0;
    end else if (stuff_now) stuff_d = 1'b1;
    else case (state_q)
      IDLE: begin
`ifdef TX_IDLE_FLAGS_EN
        cnt_d = {1'b0, cnt_q[2:0] + 3'd1};
        if (start_ok && !pend_q) begin
          pend_d = 1'b1;
          size_d = bus.Tx_FrameSize;
        end
`else
        if (start_ok) size_d = bus.Tx_FrameSize;
`endif
        if (go) begin
          state_d = FLAG_START;
          cnt_d   = '0;
          pend_d  = 1'b0;
          crc_d   = 16'hFFFF;
        end
      end
      FLAG_START, DATA: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = (state_q == DATA && byte_q == size_q - SIZE_W'(1)) ? FCS : DATA;
          byte_d  = state_q == DATA ? byte_q + SIZE_W'(1) : '0;
          cnt_d   = '0;
          data_d  = hold_q;
        end
      end
      FCS: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) state_d = FLAG_END;
      end
      FLAG_END, ABORT: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7) begin
          state_d = IDLE;
          cnt_d   = '0;
          ab_d    = state_q == ABORT;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_d = stuff_d            ? 1'b0 :
           state_d == DATA    ? data_d[cnt_d[2:0]] :
           state_d == FCS     ? ~crc_q[cnt_d] :
           state_d == ABORT   ? ABRT[cnt_d[2:0]] :
           state_d != IDLE    ? FLAG[cnt_d[2:0]] :
`ifdef TX_IDLE_FLAGS_EN
                                FLAG[cnt_d[2:0]];
`else
                                1'b1;
`endif
    if (state_d == DATA && !stuff_d)
      crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ tx_d) ? 16'h8408 : 16'h0000);
    ones_d = ((state_d == DATA || state_d == FCS) && !stuff_d && tx_d) ? ones_q + 3'd1 : 3'd0;
    rd_d   = (state_q == IDLE && state_d == FLAG_START) ||
             (state_d == DATA && !stuff_d && cnt_d == 4'd0 && byte_d + SIZE_W'(1) < size_q);
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      byte_q   <= '0;
      size_q   <= '0;
      hold_q   <= '0;
      data_q   <= '0;
      crc_q    <= '0;
      ones_q   <= '0;
      pend_q   <= 1'b0;
      rd_dly_q <= 1'b0;
      tx_q     <= 1'b1;
      rd_q     <= 1'b0;
      valid_q  <= 1'b0;
      done_q   <= 1'b1;
      ab_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      size_q   <= size_d;
      hold_q   <= hold_d;
      data_q   <= data_d;
      crc_q    <= crc_d;
      ones_q   <= ones_d;
      pend_q   <= pend_d;
      rd_dly_q <= rd_q;
      tx_q     <= tx_d;
      rd_q     <= rd_d;
      valid_q  <= state_d != IDLE;
      done_q   <= state_d == IDLE;
      ab_q     <= ab_d;
    end
  assign bus.Tx              = tx_q;
  assign bus.Tx_RdBuff       = rd_q;
  assign bus.Tx_ValidFrame   = valid_q;
  assign bus.Tx_Done         = done_q;
  assign bus.Tx_AbortedTrans = ab_q;
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: self-checking bench; expected line streams come from a queue-based HDLC frame
// model, and a destuffing receiver model stands in for the Rx channel loopback.
module tb_hdlc_tx_framer;
  localparam logic [7:0] FLAG = 8'h7E;
  localparam logic [7:0] ABRT = 8'h7F;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;
  hdlc_tx_framer_if #(.SIZE_W(8)) bus ();
  hdlc_tx_framer #(.MAX_BYTES(126), .SIZE_W(8)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

  typedef struct {
    logic       en;
    logic [7:0] size;
    logic       tx, done, valid, rd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:255];
  bit got[$];
  bit exp_bits[$];
  int rd_pos[$];
  int rd_cnt, ab_cnt, done_ok;
  logic [7:0] rx_bytes[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Line image of a complete frame: flag, stuffed data+FCS, flag; rd_pos holds the line
  // position at which each buffer fetch is due.
  function automatic void build(input int n);
    bit raw[$];
    logic [15:0] crc = 16'hFFFF;
    int ones = 0;
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++) begin
        raw.push_back(mem[i][b]);
        crc = (crc >> 1) ^ ((crc[0] ^ mem[i][b]) ? 16'h8408 : 16'h0000);
      end
    for (int b = 0; b < 16; b++) raw.push_back(~crc[b]);
    exp_bits.delete();
    rd_pos.delete();
    rd_pos.push_back(0);
    for (int b = 0; b < 8; b++) exp_bits.push_back(FLAG[b]);
    for (int j = 0; j < raw.size(); j++) begin
      if (j % 8 == 0 && j / 8 < n - 1) rd_pos.push_back(exp_bits.size());
      exp_bits.push_back(raw[j]);
      ones = raw[j] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_bits.push_back(1'b0);
        ones = 0;
      end
    end
    for (int b = 0; b < 8; b++) exp_bits.push_back(FLAG[b]);
  endfunction

  task automatic collect(input int abort_at);
    done_ok = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (bus.Tx_ValidFrame) got.push_back(bus.Tx);
      if (bus.Tx_RdBuff) begin
        bus.Tx_DataOutBuff = mem[rd_cnt & 255];
        rd_cnt++;
      end
      if (bus.Tx_AbortedTrans) ab_cnt++;
      if (bus.Tx_Done && got.size() > 0) begin
        done_ok = 1;
        break;
      end
      bus.Tx_AbortFrame = (cyc == abort_at);
      @(negedge Clk);
    end
    bus.Tx_AbortFrame = 1'b0;
  endtask

  task automatic run_frame(input int n, input int abort_at);
    got.delete();
    rd_cnt = 0;
    ab_cnt = 0;
    @(negedge Clk);
    bus.Tx_Enable    = 1'b1;
    bus.Tx_FrameSize = 8'(n);
    @(negedge Clk);
    bus.Tx_Enable    = 1'b0;
    collect(abort_at);
  endtask

  task automatic check_frame(input string tag, input int n, input int abort_at);
    bit want[$];
    int mis = 0;
    int rds = 0;
    build(n);
    if (abort_at < 0) begin
      want = exp_bits;
      rds  = rd_pos.size();
    end else begin
      for (int i = 0; i <= abort_at; i++) want.push_back(exp_bits[i]);
      for (int b = 0; b < 8; b++) want.push_back(ABRT[b]);
      foreach (rd_pos[i]) if (rd_pos[i] <= abort_at) rds++;
    end
    chk({tag, " done"}, done_ok, 1);
    chk({tag, " length"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++) if (got[i] != want[i]) mis++;
    chk({tag, " bit errors"}, mis, 0);
    chk({tag, " rd pulses"}, rd_cnt, rds);
    chk({tag, " aborted pulses"}, ab_cnt, abort_at < 0 ? 0 : 1);
  endtask

  // Receiver view: strip flags, drop the zero after five ones, rebuild bytes, verify FCS residue.
  task automatic check_rx(input string tag, input int n);
    logic [7:0] cur = 8'h00;
    logic [15:0] crc = 16'hFFFF;
    int nb = 0, ones = 0, ok = 1, mis = 0;
    rx_bytes.delete();
    for (int i = 8; i < got.size() - 8; i++) begin
      if (ones == 5) begin
        ones = 0;
        if (got[i]) ok = 0;
        continue;
      end
      ones = got[i] ? ones + 1 : 0;
      cur = {got[i], cur[7:1]};
      crc = (crc >> 1) ^ ((crc[0] ^ got[i]) ? 16'h8408 : 16'h0000);
      nb++;
      if (nb == 8) begin
        rx_bytes.push_back(cur);
        nb = 0;
      end
    end
    chk({tag, " rx stuffing"}, (ok == 1 && nb == 0) ? 1 : 0, 1);
    chk({tag, " rx byte count"}, rx_bytes.size(), n + 2);
    for (int i = 0; i < n && i < rx_bytes.size(); i++) if (rx_bytes[i] != mem[i]) mis++;
    chk({tag, " rx data errors"}, mis, 0);
    chk({tag, " rx fcs residue"}, crc, 16'hF0B8);
  endtask

  initial begin
    vec_t vecs[8];
    int cnt, maxrun, run, n, ab;
    vecs = '{
      '{1'b0, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'd127, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'd1,   1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0},
      '{1'b1, 8'd3,   1'b1, 1'b0, 1'b1, 1'b0},
      '{1'b1, 8'd9,   1'b1, 1'b0, 1'b1, 1'b0}
    };
    bus.Tx_Enable = 1'b0;
    bus.Tx_FrameSize = 8'd0;
    bus.Tx_DataOutBuff = 8'h00;
    bus.Tx_AbortFrame = 1'b0;
    repeat (2) @(negedge Clk);
    chk("reset tx", bus.Tx, 1);
    chk("reset done", bus.Tx_Done, 1);
    chk("reset valid", bus.Tx_ValidFrame, 0);
    chk("reset rd", bus.Tx_RdBuff, 0);
    chk("reset aborted", bus.Tx_AbortedTrans, 0);
    Rst = 1'b1;
    @(negedge Clk);

    // Illegal sizes ignored, legal start, Tx_Enable mid-frame ignored
    mem[0] = 8'hA5;
    got.delete();
    rd_cnt = 0;
    ab_cnt = 0;
    foreach (vecs[i]) begin
      bus.Tx_Enable = vecs[i].en;
      bus.Tx_FrameSize = vecs[i].size;
      @(negedge Clk);
      bus.Tx_Enable = 1'b0;
      chk($sformatf("vec%0d tx", i), bus.Tx, vecs[i].tx);
      chk($sformatf("vec%0d done", i), bus.Tx_Done, vecs[i].done);
      chk($sformatf("vec%0d valid", i), bus.Tx_ValidFrame, vecs[i].valid);
      chk($sformatf("vec%0d rd", i), bus.Tx_RdBuff, vecs[i].rd);
      if (bus.Tx_ValidFrame) got.push_back(bus.Tx);
      if (bus.Tx_RdBuff) begin
        bus.Tx_DataOutBuff = mem[rd_cnt & 255];
        rd_cnt++;
      end
    end
    @(negedge Clk);
    collect(-1);
    check_frame("vec frame", 1, -1);
    cnt = 0;
    repeat (30) begin
      @(negedge Clk);
      if (bus.Tx_ValidFrame || !bus.Tx_Done) cnt++;
    end
    chk("no second frame", cnt, 0);

    // Asynchronous reset in the middle of the opening flag
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'h41 + i);
    @(negedge Clk);
    bus.Tx_Enable = 1'b1;
    bus.Tx_FrameSize = 8'd5;
    @(negedge Clk);
    bus.Tx_Enable = 1'b0;
    chk("pre-reset tx", bus.Tx, 0);
    Rst = 1'b0;
    #1;
    chk("mid reset tx", bus.Tx, 1);
    chk("mid reset done", bus.Tx_Done, 1);
    chk("mid reset valid", bus.Tx_ValidFrame, 0);
    chk("mid reset rd", bus.Tx_RdBuff, 0);
    @(negedge Clk);
    Rst = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge Clk);
      if (bus.Tx_ValidFrame || !bus.Tx) cnt++;
    end
    chk("no resume after reset", cnt, 0);

    // "123456789" check vector
    for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
    run_frame(9, -1);
    check_frame("crc9", 9, -1);
    check_rx("crc9", 9);
    chk("crc9 fcs lo", rx_bytes.size() > 10 ? int'(rx_bytes[9]) : -1, 8'h6E);
    chk("crc9 fcs hi", rx_bytes.size() > 10 ? int'(rx_bytes[10]) : -1, 8'h90);

    // All-ones data forces three inserted zeros in the data field
    mem[0] = 8'hFF;
    mem[1] = 8'hFF;
    run_frame(2, -1);
    check_frame("ff", 2, -1);
    chk("ff stuffed zeros", got.size() > 25 ? int'({got[13], got[19], got[25]}) : 7, 0);
    maxrun = 0;
    run = 0;
    for (int i = 8; i < got.size() - 8; i++) begin
      run = got[i] ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    chk("ff max run", maxrun, 5);

    // Abort during the second byte: three fetches, then 0x7F and a pulse
    for (int i = 0; i < 5; i++) mem[i] = 8'(8'h11 + i);
    run_frame(5, 19);
    check_frame("abort", 5, 19);
    chk("abort done", bus.Tx_Done, 1);
    @(negedge Clk);
    chk("abort pulse width", bus.Tx_AbortedTrans, 0);

    // Random frames, some aborted at a random line position
    for (int k = 0; k < 16; k++) begin
      n = (k == 0) ? 126 : $urandom_range(1, 40);
      for (int i = 0; i < n; i++) mem[i] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      build(n);
      ab = (k > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, exp_bits.size() - 9) : -1;
      run_frame(n, ab);
      check_frame($sformatf("rand%0d", k), n, ab);
      if (ab < 0) check_rx($sformatf("rand%0d", k), n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
